// File: rtl/quad_input_filter.sv
// Synchronises raw quadrature lines, debounces the A/B pair jointly and flags double-bit jumps.
// Outputs are registered; accept latency is SYNC_STAGES+FILTER_CYCLES clocks, no backpressure.
module quad_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             A_raw,
    input  logic             B_raw,
    input  logic             clear_err,
    output logic             A,
    output logic             B,
    output logic             step,
    output logic             illegal,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0] FC = 8'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_a_q;
    logic [SYNC_STAGES-1:0] sync_b_q;
    logic [1:0]             s;

    logic [1:0]       ab_q,      ab_d;
    logic [1:0]       cand_q,    cand_d;
    logic [7:0]       cnt_q,     cnt_d;
    logic             step_q,    step_d;
    logic             illegal_q, illegal_d;
    logic [ERR_W-1:0] err_q,     err_d;
    logic             accept;

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Counter holds the number of consecutive cycles s has matched cand.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        ab_d   = ab_q;
        accept = 1'b0;

        if (s == ab_q) begin
            cnt_d = 8'd0;
        end else if (s != cand_q) begin
            cand_d = s;
            if (FC == 8'd1) begin
                accept = 1'b1;
            end else begin
                cnt_d = 8'd1;
            end
        end else if (cnt_q + 8'd1 == FC) begin
            accept = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        if (accept) begin
            ab_d  = s;
            cnt_d = 8'd0;
        end
    end

    assign step_d    = accept;
    assign illegal_d = accept && (s == ~ab_q);

    // Clear wins over a coincident increment; the counter sticks at all-ones.
    always_comb begin
        err_d = err_q;
        if (clear_err) begin
            err_d = '0;
        end else if (illegal_d && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            ab_q      <= 2'b00;
            cand_q    <= 2'b00;
            cnt_q     <= 8'd0;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            sync_a_q  <= {sync_a_q[SYNC_STAGES-2:0], A_raw};
            sync_b_q  <= {sync_b_q[SYNC_STAGES-2:0], B_raw};
            ab_q      <= ab_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign step      = step_q;
    assign illegal   = illegal_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter with default parameters (6-cycle accept latency).
module tb_quad_input_filter;

    logic       clock = 1'b0;
    logic       reset;
    logic       A_raw;
    logic       B_raw;
    logic       clear_err;
    logic       A;
    logic       B;
    logic       step;
    logic       illegal;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    quad_input_filter #(
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .ERR_W        (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .A_raw    (A_raw),
        .B_raw    (B_raw),
        .clear_err(clear_err),
        .A        (A),
        .B        (B),
        .step     (step),
        .illegal  (illegal),
        .err_count(err_count)
    );

    typedef struct {
        logic [1:0] raw;
        int         lat;
        logic       ill;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_step(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (step === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input int n, output int steps, output int ills);
        steps = 0;
        ills  = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (step === 1'b1) steps++;
            if (illegal === 1'b1) ills++;
        end
    endtask

    initial begin
        int lat, steps, ills, ahigh, first_rise, bad;
        logic [1:0] rot[8];
        logic [1:0] prev, expab, cur;

        tbl[0] = '{raw: 2'b10, lat: 6, ill: 1'b0, err: 8'd0};
        tbl[1] = '{raw: 2'b11, lat: 6, ill: 1'b0, err: 8'd0};
        tbl[2] = '{raw: 2'b01, lat: 6, ill: 1'b0, err: 8'd0};
        tbl[3] = '{raw: 2'b00, lat: 6, ill: 1'b0, err: 8'd0};
        tbl[4] = '{raw: 2'b11, lat: 6, ill: 1'b1, err: 8'd1};
        tbl[5] = '{raw: 2'b00, lat: 6, ill: 1'b1, err: 8'd2};
        tbl[6] = '{raw: 2'b01, lat: 6, ill: 1'b0, err: 8'd2};
        tbl[7] = '{raw: 2'b10, lat: 6, ill: 1'b1, err: 8'd3};
        tbl[8] = '{raw: 2'b00, lat: 6, ill: 1'b0, err: 8'd3};

        // Reset held with both raw lines high; outputs must stay cleared.
        reset = 1'b0; A_raw = 1'b1; B_raw = 1'b1; clear_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_outputs", {A, B, step, illegal, err_count}, 32'd0);
        end
        reset = 1'b1;
        wait_step(20, lat);
        check("reset_release_latency", lat, 6);
        check("reset_release_ab", {A, B}, 2'b11);
        check("reset_release_illegal", illegal, 1'b1);
        check("reset_release_err", err_count, 8'd1);

        // Return to a clean 00 state with err_count cleared.
        A_raw = 1'b0; B_raw = 1'b0; reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("clean_start", {A, B, err_count}, 32'd0);

        foreach (tbl[i]) begin
            {A_raw, B_raw} = tbl[i].raw;
            wait_step(20, lat);
            check($sformatf("row%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("row%0d_ab", i), {A, B}, tbl[i].raw);
            check($sformatf("row%0d_illegal", i), illegal, tbl[i].ill);
            check($sformatf("row%0d_err", i), err_count, tbl[i].err);
            run(14, steps, ills);
            check($sformatf("row%0d_extra_steps", i), steps, 0);
        end

        // 3-cycle glitch on A must be swallowed.
        A_raw = 1'b1;
        steps = 0; ahigh = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 3) A_raw = 1'b0;
            if (step === 1'b1) steps++;
            if (A === 1'b1) ahigh++;
        end
        check("glitch3_steps", steps, 0);
        check("glitch3_a_high", ahigh, 0);

        // 4-cycle pulse just passes: A high for 4 cycles, two steps.
        A_raw = 1'b1;
        steps = 0; ahigh = 0; first_rise = -1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 4) A_raw = 1'b0;
            if (step === 1'b1) steps++;
            if (A === 1'b1) begin
                ahigh++;
                if (first_rise < 0) first_rise = k;
            end
        end
        check("pulse4_steps", steps, 2);
        check("pulse4_a_high", ahigh, 4);
        check("pulse4_first_rise", first_rise, 6);

        // Park at 10 so the rotation below produces 8 legal steps.
        {A_raw, B_raw} = 2'b10;
        run(20, steps, ills);

        rot[0] = 2'b00; rot[1] = 2'b10; rot[2] = 2'b11; rot[3] = 2'b01;
        rot[4] = 2'b00; rot[5] = 2'b01; rot[6] = 2'b11; rot[7] = 2'b10;
        prev = 2'b10; steps = 0; ills = 0;
        for (int i = 0; i < 8; i++) begin
            {A_raw, B_raw} = rot[i];
            bad = 0;
            for (int k = 1; k <= 200; k++) begin
                tick();
                expab = (k >= 6) ? rot[i] : prev;
                if ({A, B} !== expab) bad++;
                if (step === 1'b1) steps++;
                if (illegal === 1'b1) ills++;
            end
            check($sformatf("rotation_seg%0d_mismatch_cycles", i), bad, 0);
            prev = rot[i];
        end
        check("rotation_steps", steps, 8);
        check("rotation_illegal", ills, 0);

        // Clear without an illegal event, then drive 300 illegal jumps.
        {A_raw, B_raw} = 2'b00;
        run(20, steps, ills);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_err_plain", err_count, 8'd0);

        cur = 2'b00; ills = 0;
        for (int t = 1; t <= 300; t++) begin
            cur = ~cur;
            {A_raw, B_raw} = cur;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (illegal === 1'b1) ills++;
            end
            if (t == 100) check("sat_err_at_100", err_count, 8'd100);
            if (t == 255) check("sat_err_at_255", err_count, 8'd255);
        end
        check("sat_illegal_pulses", ills, 300);
        check("sat_err_final", err_count, 8'd255);

        // clear_err sampled on the same edge that raises illegal.
        cur = ~cur;
        {A_raw, B_raw} = cur;
        for (int k = 0; k < 5; k++) tick();
        clear_err = 1'b1;
        tick();
        check("clear_coincident_illegal", illegal, 1'b1);
        check("clear_coincident_err", err_count, 8'd0);
        clear_err = 1'b0;
        tick();
        check("clear_after_err", err_count, 8'd0);
        check("step_single_cycle", step, 1'b0);

        // Reset while the filter counter is at 2 for a rising A.
        {A_raw, B_raw} = 2'b00;
        run(20, steps, ills);
        {A_raw, B_raw} = 2'b10;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midreset_a_low", A, 1'b0);
        end
        check("midreset_err_cleared", err_count, 8'd0);
        reset = 1'b1;
        wait_step(20, lat);
        check("midreset_latency", lat, 6);
        check("midreset_ab", {A, B}, 2'b10);
        run(20, steps, ills);
        check("midreset_extra_steps", steps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
